pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised, handshaked pipeline register for the inter-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries one WIDTH-bit payload per transfer, adds valid/ready flow control with a two-entry skid so stalls do not create a combinational ready path, and supports a synchronous flush for branch squash. Each stage buffer instantiates it with a WIDTH equal to its concatenated fields.

## Interface
- WIDTH, 32: payload width in bits (≥1).
- CNT_W, 16: width of performance counters (only used with PIPE_STAGE_PERF_EN).

- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  stage can accept; registered (function of state only).
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid entry; registered.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  payload of oldest entry; registered.
- stall_cnt  output  CNT_W  (PIPE_STAGE_PERF_EN only) cycles with out_valid=1, out_ready=0.
- flush_cnt  output  CNT_W  (PIPE_STAGE_PERF_EN only) flush cycles that discarded ≥1 entry.

## Operation
- Storage: main register (drives out_data) and skid register. in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- States: EMPTY (0 entries), ONE (main valid), FULL (main + skid valid).
- in_ready = (state != FULL); out_valid = (state != EMPTY).
- EMPTY: in_xfer → ONE, main ← in_data; else stay.
- ONE: in_xfer & out_xfer → ONE, main ← in_data; in_xfer only → FULL, skid ← in_data; out_xfer only → EMPTY; neither → stay.
- FULL: out_xfer → ONE, main ← skid; else stay. No input accepted.
- Order preserved: main always older than skid.
- flush (highest priority over all transitions): next state EMPTY. Any in_xfer in the flush cycle is discarded. out_xfer in the flush cycle still completes (downstream owns that word). main/skid data retain old values, which do not matter because the valid bits are cleared.
- out_data is not held stable while out_valid=0; it only holds stable while out_valid=1 and out_ready=0.

## Timing
- Reset (async, immediate): state EMPTY, in_ready=1, out_valid=0, out_data=0, skid=0, counters=0.
- Reset deassertion is sampled at clk; first in_xfer possible on the first edge after deassertion.
- Latency: in_xfer at edge N → out_valid=1 with that data after edge N (1 cycle).
- Throughput: 1 transfer per cycle with out_ready held at 1.
- Stall: out_ready falls → at most one more word is absorbed (into skid), then in_ready=0 from the next cycle.
- Release from FULL: out_xfer at edge N → in_ready=1 after edge N; skid data appears on out_data the same edge.
- No combinational path from out_ready to in_ready, or from in_* to out_*.

## Configuration
- PIPE_STAGE_PERF_EN defined: stall_cnt and flush_cnt ports and counters exist. Both counters increment once per qualifying cycle and saturate at all-ones. A flush on a non-empty stage counts once, even if it discards two entries. Both counters reset to 0 only on rst.
- Undefined: both ports and all counter logic are absent. Datapath behaviour is identical.

## Test plan
- Reset mid-FULL: fill with 0xA, 0xB, assert rst asynchronously between edges → out_valid=0, in_ready=1, out_data=0 immediately, without waiting for an edge.
- Streaming: out_ready=1, in_valid=1 with data 1,2,3,…,100 → out_data 1..100 in order, one per cycle, 1-cycle latency, in_ready constantly 1.
- Skid: stream 0x10,0x11,0x12 and drop out_ready after 0x10 is presented → 0x11 held in skid, in_ready=0, 0x12 held upstream; raise out_ready → 0x10, 0x11, 0x12 delivered in order with no loss or duplication.
- Flush in FULL with in_valid=1 and out_ready=1 → word on out_data consumed, next cycle out_valid=0, skid and input words discarded; with macro, flush_cnt=1.
- Flush when EMPTY with in_valid=1 (data 0x55) → 0x55 dropped, out_valid stays 0; with macro, flush_cnt unchanged.
- Random valid/ready (≥10k cycles) against a scoreboard FIFO → no loss, duplication or reorder; with macro, stall_cnt equals the count of cycles with out_valid=1 and out_ready=0 (CNT_W=4 also checks saturation at 15).

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a two-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module pipe_stage_skid #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_xfer, out_xfer;

   // Handshake outputs depend on the state register only, so no ready/valid feedthrough.
   assign in_ready  = (state_q != StFull);
   assign out_valid = (state_q != StEmpty);
   assign out_data  = main_q;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         StEmpty: begin
            if (in_xfer) begin
               state_d = StOne;
               main_d  = in_data;
            end
         end
         StOne: begin
            if (in_xfer && out_xfer) begin
               main_d = in_data;
            end else if (in_xfer) begin
               state_d = StFull;
               skid_d  = in_data;
            end else if (out_xfer) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            if (out_xfer) begin
               state_d = StOne;
               main_d  = skid_q;
            end
         end
         default: state_d = StEmpty;
      endcase
      // Flush only clears occupancy; stale data is harmless once valid is gone.
      if (flush) begin
         state_d = StEmpty;
         main_d  = main_q;
         skid_d  = skid_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StEmpty;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      // One count per flush cycle regardless of how many entries were dropped.
      if (flush && (state_q != StEmpty) && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   // CNT_W only sizes the counters; keep it referenced when they are absent.
   logic [CNT_W-1:0] unused_cnt;
   assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed scenarios plus a random valid/ready soak.
module tb_pipe_stage_skid;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
`endif

   pipe_stage_skid #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] sb_q[$];
   logic [WIDTH-1:0] got[$];
   bit               exp_ir, exp_ov;
   longint           stall_m = 0;
   longint           flush_m = 0;
   longint           cnt_max = (longint'(1) << CNT_W) - 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: inputs are stable at the falling edge, so compare and advance the model there.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         stall_m = 0;
         flush_m = 0;
      end else begin
         exp_ir = (sb_q.size() < 2);
         exp_ov = (sb_q.size() != 0);
         check("in_ready", 64'(in_ready), 64'(exp_ir));
         check("out_valid", 64'(out_valid), 64'(exp_ov));
         if (exp_ov) check("out_data", 64'(out_data), 64'(sb_q[0]));
`ifdef PIPE_STAGE_PERF_EN
         check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
         check("flush_cnt", 64'(flush_cnt), 64'(flush_m));
         if (exp_ov && !out_ready && stall_m != cnt_max) stall_m++;
         if (flush && exp_ov && flush_m != cnt_max) flush_m++;
`endif
         if (exp_ov && out_ready) begin
            got.push_back(out_data);
            void'(sb_q.pop_front());
         end
         if (flush) sb_q.delete();
         else if (exp_ir && in_valid) sb_q.push_back(in_data);
      end
   end

   task automatic cyc(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                      input logic fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #3;
      check("reset in_ready", 64'(in_ready), 64'd1);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset out_data", 64'(out_data), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Streaming 1..100 with downstream always ready.
      got.delete();
      for (int i = 1; i <= 100; i++) cyc(1'b1, WIDTH'(i), 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      check("stream count", 64'(got.size()), 64'd100);
      if (got.size() == 100) begin
         for (int k = 0; k < 100; k++) check("stream order", 64'(got[k]), 64'(k + 1));
      end

      // Skid: 0x11 lands in skid, 0x12 held upstream until space frees.
      got.delete();
      cyc(1'b1, 32'h10, 1'b1, 1'b0);
      cyc(1'b1, 32'h11, 1'b0, 1'b0);
      cyc(1'b1, 32'h12, 1'b0, 1'b0);
      cyc(1'b1, 32'h12, 1'b0, 1'b0);
      cyc(1'b1, 32'h12, 1'b1, 1'b0);
      cyc(1'b1, 32'h12, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      check("skid count", 64'(got.size()), 64'd3);
      if (got.size() == 3) begin
         check("skid word0", 64'(got[0]), 64'h10);
         check("skid word1", 64'(got[1]), 64'h11);
         check("skid word2", 64'(got[2]), 64'h12);
      end

      // Flush while FULL: head word still consumed, skid and input word dropped.
      got.delete();
      cyc(1'b1, 32'hA, 1'b0, 1'b0);
      cyc(1'b1, 32'hB, 1'b0, 1'b0);
      cyc(1'b1, 32'hC, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      check("flush-full count", 64'(got.size()), 64'd1);
      if (got.size() == 1) check("flush-full word", 64'(got[0]), 64'hA);
`ifdef PIPE_STAGE_PERF_EN
      check("flush-full flush_cnt", 64'(flush_cnt), 64'd1);
      check("flush-full stall_cnt", 64'(stall_cnt), 64'd4);
`endif

      // Flush while EMPTY: incoming 0x55 discarded.
      got.delete();
      cyc(1'b1, 32'h55, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      check("flush-empty count", 64'(got.size()), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
      check("flush-empty flush_cnt", 64'(flush_cnt), 64'd1);
`endif

      // Asynchronous reset while FULL, asserted between edges.
      cyc(1'b1, 32'hA, 1'b0, 1'b0);
      cyc(1'b1, 32'hB, 1'b0, 1'b0);
      #2;
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      check("async rst out_valid", 64'(out_valid), 64'd0);
      check("async rst in_ready", 64'(in_ready), 64'd1);
      check("async rst out_data", 64'(out_data), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
      check("async rst stall_cnt", 64'(stall_cnt), 64'd0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Random valid/ready/flush soak against the scoreboard.
      for (int i = 0; i < 10000; i++) begin
         cyc(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), 1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 63) == 0));
      end
      for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
